// File: rtl/rdma_mq_controller_if.sv
// Handshake and stream bundle between the multi-QP RDMA controller and its
// data-mover, descriptor parser, TX streamer and CQ-entry stream neighbours.
interface rdma_mq_controller_if;
  logic         desc_valid;
  logic [31:0]  desc_id;
  logic [7:0]   desc_opcode;
  logic [31:0]  desc_local_addr;
  logic [63:0]  desc_remote_addr;
  logic [31:0]  desc_rkey;
  logic [31:0]  desc_length;

  logic         CMD_CTRL_READY;
  logic         CMD_CTRL_START;
  logic [31:0]  CMD_CTRL_SRC_ADDR;
  logic [31:0]  CMD_CTRL_DST_ADDR;
  logic [31:0]  CMD_CTRL_BTT;
  logic         CMD_CTRL_IS_READ;
  logic         READ_COMPLETE;
  logic         WRITE_COMPLETE;

  logic         tx_cmd_valid;
  logic         tx_cmd_ready;
  logic [3:0]   tx_cmd_qp;
  logic [7:0]   tx_cmd_sq_index;
  logic [31:0]  tx_cmd_ddr_addr;
  logic [31:0]  tx_cmd_length;
  logic [7:0]   tx_cmd_opcode;
  logic [63:0]  tx_cmd_remote_addr;
  logic [31:0]  tx_cmd_rkey;
  logic [23:0]  tx_cmd_psn;

  logic         tx_cpl_valid;
  logic         tx_cpl_ready;
  logic [7:0]   tx_cpl_status;
  logic [31:0]  tx_cpl_bytes_sent;

  logic         START_STREAM;
  logic         IS_STREAM_BUSY;
  logic [255:0] cq_entry;

  modport master (
    input  desc_valid, desc_id, desc_opcode, desc_local_addr, desc_remote_addr,
           desc_rkey, desc_length, CMD_CTRL_READY, READ_COMPLETE, WRITE_COMPLETE,
           tx_cmd_ready, tx_cpl_valid, tx_cpl_status, tx_cpl_bytes_sent, IS_STREAM_BUSY,
    output CMD_CTRL_START, CMD_CTRL_SRC_ADDR, CMD_CTRL_DST_ADDR, CMD_CTRL_BTT,
           CMD_CTRL_IS_READ, tx_cmd_valid, tx_cmd_qp, tx_cmd_sq_index, tx_cmd_ddr_addr,
           tx_cmd_length, tx_cmd_opcode, tx_cmd_remote_addr, tx_cmd_rkey, tx_cmd_psn,
           tx_cpl_ready, START_STREAM, cq_entry
  );

  modport slave (
    output desc_valid, desc_id, desc_opcode, desc_local_addr, desc_remote_addr,
           desc_rkey, desc_length, CMD_CTRL_READY, READ_COMPLETE, WRITE_COMPLETE,
           tx_cmd_ready, tx_cpl_valid, tx_cpl_status, tx_cpl_bytes_sent, IS_STREAM_BUSY,
    input  CMD_CTRL_START, CMD_CTRL_SRC_ADDR, CMD_CTRL_DST_ADDR, CMD_CTRL_BTT,
           CMD_CTRL_IS_READ, tx_cmd_valid, tx_cmd_qp, tx_cmd_sq_index, tx_cmd_ddr_addr,
           tx_cmd_length, tx_cmd_opcode, tx_cmd_remote_addr, tx_cmd_rkey, tx_cmd_psn,
           tx_cpl_ready, START_STREAM, cq_entry
  );
endinterface

// File: rtl/rdma_mq_controller.sv
// Multi-QP RDMA TX controller: round-robin over send queues, fetch descriptor,
// issue TX command with per-QP PSN, then post a 32-byte entry to the shared CQ.
module rdma_mq_controller #(
  parameter int NUM_QP     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         START_RDMA,
  input  logic [NUM_QP*ADDR_WIDTH-1:0] SQ_BASE_ADDR,
  input  logic [NUM_QP*IDX_WIDTH-1:0]  SQ_SIZE,
  input  logic [NUM_QP*IDX_WIDTH-1:0]  SQ_TAIL_SW,
  output logic [NUM_QP*IDX_WIDTH-1:0]  SQ_HEAD_HW,
  input  logic [ADDR_WIDTH-1:0]        CQ_BASE_ADDR,
  input  logic [IDX_WIDTH-1:0]         CQ_SIZE,
  input  logic [IDX_WIDTH-1:0]         CQ_HEAD_SW,
  output logic [IDX_WIDTH-1:0]         CQ_TAIL_HW,
  output logic [3:0]                   STATE_REG,
  output logic [NUM_QP-1:0]            HAS_WORK,
  output logic [15:0]                  ERR_COUNT,
  rdma_mq_controller_if.master         bus
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, ARB, PREP_RD, RD_CMD, WAIT_RD, WAIT_DESC, SEND_TX,
    WAIT_CPL, CQ_CHK, PREP_WR, WR_CMD, START_STRM, WAIT_WR
  } state_e;

  function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] idx,
                                                    input logic [IDX_WIDTH-1:0] size);
    logic [IDX_WIDTH-1:0] inc;
    inc = idx + IDX_WIDTH'(1);
    return (inc == size) ? '0 : inc;
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           cur_qp_q, last_served_q, arb_qp;
  logic                 arb_found;
  logic [4:0]           cand;
  logic [IDX_WIDTH-1:0] cq_tail_q, cq_tail_next;
  logic [IDX_WIDTH-1:0] head_w [NUM_QP];
  logic [23:0]          psn_w [NUM_QP];
  logic [IDX_WIDTH-1:0] cur_head;
  logic [23:0]          cur_psn, psn_used_q;
  logic [ADDR_WIDTH-1:0] cur_base;
  logic                 desc_got_q;
  logic [31:0]          desc_id_q, desc_local_q, desc_rkey_q, desc_length_q;
  logic [7:0]           desc_opcode_q, status_q;
  logic [63:0]          desc_remote_q;
  logic [31:0]          bytes_q, src_q, dst_q, btt_q;
  logic                 is_read_q, cmd_start_q, cmd_start_d, start_stream_q, start_stream_d;
  logic [15:0]          err_cnt_q;
  logic [255:0]         cq_entry_q;

  // Per-QP ring state: head advances on CQ write completion, PSN on TX handshake.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_QP; gi++) begin : g_qp
      logic [IDX_WIDTH-1:0] head_q;
      logic [23:0]          psn_q;
      logic                 sel;
      assign sel = (cur_qp_q == 4'(gi));
      always_ff @(posedge clk) begin
        if (rst) begin
          head_q <= '0;
          psn_q  <= '0;
        end else begin
          if (sel && state_q == WAIT_WR && bus.WRITE_COMPLETE)
            head_q <= wrap_inc(head_q, SQ_SIZE[gi*IDX_WIDTH +: IDX_WIDTH]);
          if (sel && state_q == SEND_TX && bus.tx_cmd_ready)
            psn_q <= psn_q + 24'd1;
        end
      end
      assign head_w[gi] = head_q;
      assign psn_w[gi]  = psn_q;
      assign SQ_HEAD_HW[gi*IDX_WIDTH +: IDX_WIDTH] = head_q;
      assign HAS_WORK[gi] = (head_q != SQ_TAIL_SW[gi*IDX_WIDTH +: IDX_WIDTH]);
    end
  endgenerate

  always_comb begin
    cur_head = '0;
    cur_psn  = '0;
    cur_base = '0;
    for (int i = 0; i < NUM_QP; i++) begin
      if (cur_qp_q == 4'(i)) begin
        cur_head = head_w[i];
        cur_psn  = psn_w[i];
        cur_base = SQ_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Search starts one past the last served QP so every queue gets a turn.
  always_comb begin
    arb_found = 1'b0;
    arb_qp    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_QP; k++) begin
      cand = 5'(last_served_q) + 5'(k);
      if (cand >= 5'(NUM_QP)) cand = cand - 5'(NUM_QP);
      for (int j = 0; j < NUM_QP; j++) begin
        if (!arb_found && cand == 5'(j) && HAS_WORK[j]) begin
          arb_found = 1'b1;
          arb_qp    = 4'(j);
        end
      end
    end
  end

  assign cq_tail_next = wrap_inc(cq_tail_q, CQ_SIZE);

  always_comb begin
    state_d        = state_q;
    cmd_start_d    = 1'b0;
    start_stream_d = 1'b0;
    case (state_q)
      IDLE:       if (START_RDMA && |HAS_WORK) state_d = ARB;
      ARB:        state_d = arb_found ? PREP_RD : IDLE;
      PREP_RD:    state_d = RD_CMD;
      RD_CMD:     if (bus.CMD_CTRL_READY) begin
                    cmd_start_d = 1'b1;
                    state_d     = WAIT_RD;
                  end
      WAIT_RD:    if (bus.READ_COMPLETE) state_d = WAIT_DESC;
      WAIT_DESC:  if (desc_got_q && !bus.IS_STREAM_BUSY) state_d = SEND_TX;
      SEND_TX:    if (bus.tx_cmd_ready) state_d = WAIT_CPL;
      WAIT_CPL:   if (bus.tx_cpl_valid) state_d = CQ_CHK;
      CQ_CHK:     if (cq_tail_next != CQ_HEAD_SW) state_d = PREP_WR;
      PREP_WR:    state_d = WR_CMD;
      WR_CMD:     if (bus.CMD_CTRL_READY) begin
                    cmd_start_d = 1'b1;
                    state_d     = START_STRM;
                  end
      START_STRM: begin
                    start_stream_d = 1'b1;
                    state_d        = WAIT_WR;
                  end
      WAIT_WR:    if (bus.WRITE_COMPLETE) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cur_qp_q       <= '0;
      last_served_q  <= 4'(NUM_QP - 1);
      cq_tail_q      <= '0;
      desc_got_q     <= 1'b0;
      desc_id_q      <= '0;
      desc_local_q   <= '0;
      desc_rkey_q    <= '0;
      desc_length_q  <= '0;
      desc_opcode_q  <= '0;
      desc_remote_q  <= '0;
      status_q       <= '0;
      bytes_q        <= '0;
      psn_used_q     <= '0;
      err_cnt_q      <= '0;
      cq_entry_q     <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      btt_q          <= '0;
      is_read_q      <= 1'b1;
      cmd_start_q    <= 1'b0;
      start_stream_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_start_q    <= cmd_start_d;
      start_stream_q <= start_stream_d;
      case (state_q)
        ARB: begin
          desc_got_q <= 1'b0;
          if (arb_found) cur_qp_q <= arb_qp;
        end
        PREP_RD: begin
          src_q     <= 32'(cur_base) + (32'(cur_head) << 6);
          btt_q     <= 32'd64;
          is_read_q <= 1'b1;
        end
        WAIT_RD, WAIT_DESC: if (bus.desc_valid) begin
          desc_got_q    <= 1'b1;
          desc_id_q     <= bus.desc_id;
          desc_local_q  <= bus.desc_local_addr;
          desc_rkey_q   <= bus.desc_rkey;
          desc_length_q <= bus.desc_length;
          desc_opcode_q <= bus.desc_opcode;
          desc_remote_q <= bus.desc_remote_addr;
        end
        SEND_TX: if (bus.tx_cmd_ready) psn_used_q <= cur_psn;
        WAIT_CPL: if (bus.tx_cpl_valid) begin
          status_q <= bus.tx_cpl_status;
          bytes_q  <= bus.tx_cpl_bytes_sent;
          if (bus.tx_cpl_status != 8'd0 && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
        end
        CQ_CHK: if (cq_tail_next != CQ_HEAD_SW)
          cq_entry_q <= {32'd0, 32'd0, {8'd0, psn_used_q}, desc_length_q, desc_id_q,
                         bytes_q, {24'd0, status_q}, {16'd0, 4'd0, cur_qp_q, 8'(cur_head)}};
        PREP_WR: begin
          dst_q     <= 32'(CQ_BASE_ADDR) + (32'(cq_tail_q) << 5);
          btt_q     <= 32'd32;
          is_read_q <= 1'b0;
        end
        WAIT_WR: if (bus.WRITE_COMPLETE) begin
          cq_tail_q     <= cq_tail_next;
          last_served_q <= cur_qp_q;
        end
        default: ;
      endcase
    end
  end

  assign STATE_REG              = state_q;
  assign CQ_TAIL_HW             = cq_tail_q;
  assign ERR_COUNT              = err_cnt_q;
  assign bus.CMD_CTRL_START     = cmd_start_q;
  assign bus.CMD_CTRL_SRC_ADDR  = src_q;
  assign bus.CMD_CTRL_DST_ADDR  = dst_q;
  assign bus.CMD_CTRL_BTT       = btt_q;
  assign bus.CMD_CTRL_IS_READ   = is_read_q;
  assign bus.START_STREAM       = start_stream_q;
  assign bus.cq_entry           = cq_entry_q;
  assign bus.tx_cmd_valid       = (state_q == SEND_TX);
  assign bus.tx_cpl_ready       = (state_q == WAIT_CPL);
  assign bus.tx_cmd_qp          = cur_qp_q;
  assign bus.tx_cmd_sq_index    = 8'(cur_head);
  assign bus.tx_cmd_ddr_addr    = desc_local_q;
  assign bus.tx_cmd_length      = desc_length_q;
  assign bus.tx_cmd_opcode      = desc_opcode_q;
  assign bus.tx_cmd_remote_addr = desc_remote_q;
  assign bus.tx_cmd_rkey        = desc_rkey_q;
  assign bus.tx_cmd_psn         = cur_psn;
endmodule

// File: doc/rdma_mq_controller.md
# rdma_mq_controller

Multi-queue-pair successor of the single-SQ RDMA TX controller. It serves `NUM_QP` send queues with round-robin arbitration. For each work request it fetches the 64-byte SQ descriptor through the unified command controller, issues a TX-streamer command carrying a per-QP PSN, waits for the TX completion, and writes a 32-byte entry to a shared completion queue. It sits between the AXI-Lite register block and the data-mover / TX-streamer path, and adds CQ-full back-pressure and error accounting.

## Interface
- `NUM_QP`, 4: number of send queues (1..16).
- `ADDR_WIDTH`, 32: DDR address width.
- `IDX_WIDTH`, 16: SQ/CQ index width.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `START_RDMA` in 1: global enable, sampled in IDLE only.
- `SQ_BASE_ADDR` in NUM_QP*ADDR_WIDTH: per-QP SQ ring base, QP i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `SQ_SIZE` in NUM_QP*IDX_WIDTH: per-QP ring depth in entries, 2..2^IDX_WIDTH-1.
- `SQ_TAIL_SW` in NUM_QP*IDX_WIDTH: software producer indices.
- `SQ_HEAD_HW` out NUM_QP*IDX_WIDTH: hardware consumer indices.
- `CQ_BASE_ADDR` in ADDR_WIDTH; `CQ_SIZE` in IDX_WIDTH; `CQ_HEAD_SW` in IDX_WIDTH: shared CQ configuration and consumer index.
- `CQ_TAIL_HW` out IDX_WIDTH: CQ producer index.
- `desc_valid` in 1; `desc_id` in 32; `desc_opcode` in 8; `desc_local_addr` in 32; `desc_remote_addr` in 64; `desc_rkey` in 32; `desc_length` in 32: parsed descriptor from the slave stream parser.
- `CMD_CTRL_READY` in 1; `CMD_CTRL_START` out 1; `CMD_CTRL_SRC_ADDR`, `CMD_CTRL_DST_ADDR`, `CMD_CTRL_BTT` out 32 each; `CMD_CTRL_IS_READ` out 1: data-mover command.
- `READ_COMPLETE` in 1; `WRITE_COMPLETE` in 1: data-mover done pulses.
- `tx_cmd_valid` out 1; `tx_cmd_ready` in 1: TX command handshake.
- `tx_cmd_qp` out 4; `tx_cmd_sq_index` out 8; `tx_cmd_ddr_addr` out 32; `tx_cmd_length` out 32; `tx_cmd_opcode` out 8; `tx_cmd_remote_addr` out 64; `tx_cmd_rkey` out 32; `tx_cmd_psn` out 24: TX command payload.
- `tx_cpl_valid` in 1; `tx_cpl_ready` out 1; `tx_cpl_status` in 8; `tx_cpl_bytes_sent` in 32: TX completion.
- `START_STREAM` out 1: one-cycle pulse that launches the CQ-entry master stream.
- `IS_STREAM_BUSY` in 1: CQ master stream busy.
- `cq_entry` out 256: CQ entry; word k at [32k +: 32].
- `STATE_REG` out 4: current state.
- `HAS_WORK` out NUM_QP: per-QP head != tail.
- `ERR_COUNT` out 16: count of completions with nonzero status; saturates at 0xFFFF.

## Operation
- **Reset.** All heads, CQ tail, PSNs, `ERR_COUNT`, `cq_entry`, and all strobes/valids are 0. `CMD_CTRL_IS_READ`=1. State is IDLE (0).
- **Work detection.** QP i has work when head[i] != tail[i].
- **Arbitration.** Round-robin. Search starts at last_served+1 mod NUM_QP; last_served resets to NUM_QP-1, so QP0 has first priority. The selected QP index is latched as cur_qp.
- **States and transitions.**
  - IDLE(0) → ARB when `START_RDMA` and any HAS_WORK.
  - ARB(1): latch cur_qp; → PREP_RD.
  - PREP_RD(2): SRC = SQ_BASE[cur] + (head[cur] << 6), BTT = 64, IS_READ = 1; → RD_CMD.
  - RD_CMD(3): when `CMD_CTRL_READY`, pulse START; → WAIT_RD.
  - WAIT_RD(4): on `READ_COMPLETE` → WAIT_DESC.
  - WAIT_DESC(5): → SEND_TX once a descriptor has been latched and `IS_STREAM_BUSY`=0.
  - SEND_TX(6): hold `tx_cmd_valid` with a stable payload until `tx_cmd_ready`. On the handshake, psn[cur] increments (mod 2^24); → WAIT_CPL.
  - WAIT_CPL(7): `tx_cpl_ready`=1 only in this state. On `tx_cpl_valid`, latch status and bytes; → CQ_CHK.
  - CQ_CHK(8): if cq_tail_next == `CQ_HEAD_SW`, the CQ is full: stay here. Otherwise build the entry → PREP_WR.
  - PREP_WR(9): DST = CQ_BASE + (cq_tail << 5), BTT = 32, IS_READ = 0; → WR_CMD.
  - WR_CMD(10): when ready, pulse START; → START_STRM.
  - START_STRM(11): pulse `START_STREAM`; → WAIT_WR.
  - WAIT_WR(12): on `WRITE_COMPLETE`, advance head[cur] and cq_tail, set last_served = cur; → IDLE.
  - Undefined states → IDLE.
- **Descriptor capture.** A descriptor is latched when `desc_valid` is high in WAIT_RD or WAIT_DESC. `desc_valid` in any other state is ignored.
- **CQ entry words.**
  - w0 = {16'd0, cur_qp[7:0], head[cur][7:0]}
  - w1 = {24'd0, status}
  - w2 = bytes_sent
  - w3 = desc_id
  - w4 = desc_length
  - w5 = {8'd0, psn used}
  - w6 = 0
  - w7 = 0
- **Wrap-around.** Index wrap is (idx+1 == SIZE) ? 0 : idx+1. Address shifts are computed at 32 bits; overflow is discarded.
- **Error counting.** A nonzero `tx_cpl_status` increments `ERR_COUNT` and saturates. The CQ entry is still written.
- **Enable behaviour.** `START_RDMA` deassertion mid-request does not abort; the FSM finishes and returns to IDLE.
- **Mid-operation reset.** `rst` mid-operation returns everything to reset values on the next edge. Pointers do not advance.

## Timing
- `CMD_CTRL_START` and `START_STREAM` are registered single-cycle pulses.
- `CMD_CTRL_START` asserts the cycle after the RD_CMD/WR_CMD cycle that sees ready.
- The address, BTT, and IS_READ outputs are stable from PREP_* until the next PREP_*.
- The `tx_cmd_*` payload is stable while `tx_cmd_valid` is high.
- Minimum IDLE→IDLE latency with zero-wait handshakes is 13 cycles.
- Pointer updates are visible on `SQ_HEAD_HW`/`CQ_TAIL_HW` the cycle after `WRITE_COMPLETE`.

## Test plan
- **Single request.** QP0 tail=1, SQ_BASE0=0x1000: SRC=0x1000, BTT=64, IS_READ=1. The TX command carries psn=0. The CQ write goes to DST=CQ_BASE with BTT=32. Afterwards head0=1, CQ_TAIL_HW=1.
- **Round-robin.** QP0..3 each hold 2 entries: service order is 0,1,2,3,0,1,2,3. psn per QP ends at 2.
- **SQ wrap.** SQ_SIZE1=4, head1=3, tail1=0: the fetch address is base+0xC0, and head1 wraps to 0.
- **CQ full.** CQ_SIZE=4, CQ_HEAD_SW=0, cq_tail=3: FSM holds in CQ_CHK (STATE_REG=8). Setting CQ_HEAD_SW=1 releases it, and the write goes to CQ_BASE+0x60.
- **Error and back-pressure.** `tx_cmd_ready` is held low for 5 cycles: valid and payload stay stable. tx_cpl_status=0x03 gives ERR_COUNT=1 and w1=0x3.
- **Reset mid-operation.** `rst` in WAIT_CPL: outputs return to reset values, heads remain 0, and a new START_RDMA re-fetches the same descriptor.
